// File: rtl/debug_pkg.sv
// Shared field layout, sizes and queue-entry type for the debug event stager.
// Bit positions refer to the 53-bit word handed to the ILA debug input.
package debug_pkg;
  localparam int NSRC       = 4;
  localparam int SRC_W      = 2;
  localparam int DATA_W     = 16;
  localparam int TS_W       = 32;
  localparam int DEBUG_W    = 53;

  localparam int VALID_BIT  = 52;
  localparam int LOST_BIT   = 51;
  localparam int SRC_LSB    = 49;
  localparam int DATA_LSB   = 33;
  localparam int TS_LSB     = 1;
  localparam int TOGGLE_BIT = 0;

  // Field order matches debug word bits [51:1], so an entry drops straight in.
  typedef struct packed {
    logic              lost;
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/debug_event_stager_if.sv
// Event-strobe inputs and staged debug word of the stager.
// master = event producer / debug consumer side, slave = the stager itself.
interface debug_event_stager_if;
  import debug_pkg::*;

  logic                     enable_i;
  logic [NSRC-1:0]          evt_i;
  logic [NSRC*DATA_W-1:0]   evt_data_i;
  logic [DEBUG_W-1:0]       debug_o;

  modport master (output enable_i, output evt_i, output evt_data_i, input debug_o);
  modport slave  (input enable_i, input evt_i, input evt_data_i, output debug_o);
endinterface

// File: rtl/debug_sync_fifo.sv
// Synchronous FIFO, first-word fall-through read, sync active-low reset.
// Push while full is accepted only when a pop happens on the same edge.
module debug_sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [AWIDTH:0]   cnt_q;
  logic              do_push, do_pop;

  assign full_o    = (cnt_q == (AWIDTH+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AWIDTH{1'b0}}, do_push} - {{AWIDTH{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// File: rtl/debug_event_stager.sv
// Timestamps single-cycle strobes from four sources and serialises them onto a
// 53-bit ILA debug word, one per cycle; drops on a busy source are flagged as lost.
module debug_event_stager
  import debug_pkg::*;
#(
  parameter int FIFO_AWIDTH = 3
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  debug_event_stager_if.slave bus
);
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [NSRC-1:0]    busy_q, busy_d, lost_q, lost_d, pend_q, pend_d;
  logic [DATA_W-1:0]  data_q [NSRC];
  logic [DATA_W-1:0]  data_d [NSRC];
  logic [TS_W-1:0]    stamp_q [NSRC];
  logic [TS_W-1:0]    stamp_d [NSRC];
  logic [SRC_W-1:0]   ptr_q, ptr_d;
  logic [DEBUG_W-1:0] debug_q, debug_d;

  logic               gnt_vld, grant;
  logic [SRC_W-1:0]   gnt_idx, scan_idx;
  logic               fifo_full, fifo_empty, fifo_pop;
  entry_t             push_ent, pop_ent;

  // First busy holding register at or after the round-robin pointer.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      scan_idx = ptr_q + SRC_W'(i);
      if (!gnt_vld && busy_q[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign fifo_pop = !fifo_empty;
  assign grant    = gnt_vld && (!fifo_full || fifo_pop);
  assign push_ent = '{lost: lost_q[gnt_idx], src: gnt_idx,
                      data: data_q[gnt_idx], ts: stamp_q[gnt_idx]};

  debug_sync_fifo #(
    .WIDTH  (ENTRY_W),
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (grant),
    .push_dat_i (push_ent),
    .pop_i      (fifo_pop),
    .pop_dat_o  (pop_ent),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    ts_d    = ts_q + 1'b1;
    busy_d  = busy_q;
    lost_d  = lost_q;
    pend_d  = pend_q;
    data_d  = data_q;
    stamp_d = stamp_q;
    ptr_d   = grant ? gnt_idx + 1'b1 : ptr_q;
    for (int k = 0; k < NSRC; k++) begin
      if (grant && gnt_idx == SRC_W'(k)) busy_d[k] = 1'b0;
      // A register being drained this edge can take a new strobe at once.
      if (bus.enable_i && bus.evt_i[k]) begin
        if (!busy_d[k]) begin
          busy_d[k]  = 1'b1;
          lost_d[k]  = pend_q[k];
          pend_d[k]  = 1'b0;
          data_d[k]  = bus.evt_data_i[k*DATA_W +: DATA_W];
          stamp_d[k] = ts_q;
        end else begin
          pend_d[k]  = 1'b1;
        end
      end
    end
    if (fifo_pop) begin
      debug_d = {1'b1, pop_ent, ~debug_q[TOGGLE_BIT]};
    end else begin
      debug_d            = debug_q;
      debug_d[VALID_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ts_q    <= '0;
      busy_q  <= '0;
      lost_q  <= '0;
      pend_q  <= '0;
      data_q  <= '{default: '0};
      stamp_q <= '{default: '0};
      ptr_q   <= '0;
      debug_q <= '0;
    end else begin
      ts_q    <= ts_d;
      busy_q  <= busy_d;
      lost_q  <= lost_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      stamp_q <= stamp_d;
      ptr_q   <= ptr_d;
      debug_q <= debug_d;
    end
  end

  assign bus.debug_o = debug_q;
endmodule
